// File: rtl/crc3_frame_checker_if.sv
// Codeword-in / checked-result-out handshake bundle for crc3_frame_checker.
// master = codeword source plus result consumer; slave = the checker.
interface crc3_frame_checker_if;
    logic       cw_valid;
    logic       cw_ready;
    logic [7:0] cw_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_msg;
    logic       out_ok;
    logic [2:0] out_syndrome;

    modport master (
        output cw_valid, cw_data, out_ready,
        input  cw_ready, out_valid, out_msg, out_ok, out_syndrome
    );

    modport slave (
        input  cw_valid, cw_data, out_ready,
        output cw_ready, out_valid, out_msg, out_ok, out_syndrome
    );
endinterface

// File: rtl/crc3_frame_checker.sv
// Serial CRC-3 checker: re-runs the encoder LFSR over a 5-bit message plus
// three zero flush bits, compares with the received CRC, and counts frames/errors.
module crc3_frame_checker #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clear_cnt,
    crc3_frame_checker_if.slave  link,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     err_cnt
);
    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    state_t             state_reg, state_next;
    logic [7:0]         data_reg, data_next;
    logic [2:0]         crc_reg, crc_next;
    logic [2:0]         idx_reg, idx_next;
    logic               out_valid_reg, out_valid_next;
    logic [4:0]         out_msg_reg, out_msg_next;
    logic               out_ok_reg, out_ok_next;
    logic [2:0]         syn_reg, syn_next;
    logic [CNT_W-1:0]   frame_cnt_reg, frame_cnt_next;
    logic [CNT_W-1:0]   err_cnt_reg, err_cnt_next;

    logic               step_bit;
    logic [2:0]         crc_step;
    logic [2:0]         syn_step;
    logic               last_step;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Steps 5..7 feed zeros to flush the message through the register.
    assign step_bit  = (idx_reg < 3'd5) ? data_reg[3'd7 - idx_reg] : 1'b0;
    assign crc_step  = {step_bit ^ crc_reg[2] ^ crc_reg[0], crc_reg[2:1]};
    assign syn_step  = crc_step ^ data_reg[2:0];
    assign last_step = (state_reg == CHECK) && (idx_reg == 3'd7);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            data_reg      <= '0;
            crc_reg       <= '0;
            idx_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_msg_reg   <= '0;
            out_ok_reg    <= 1'b0;
            syn_reg       <= '0;
            frame_cnt_reg <= '0;
            err_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            data_reg      <= data_next;
            crc_reg       <= crc_next;
            idx_reg       <= idx_next;
            out_valid_reg <= out_valid_next;
            out_msg_reg   <= out_msg_next;
            out_ok_reg    <= out_ok_next;
            syn_reg       <= syn_next;
            frame_cnt_reg <= frame_cnt_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        data_next      = data_reg;
        crc_next       = crc_reg;
        idx_next       = idx_reg;
        out_valid_next = out_valid_reg;
        out_msg_next   = out_msg_reg;
        out_ok_next    = out_ok_reg;
        syn_next       = syn_reg;
        if (en) begin
            case (state_reg)
                IDLE: begin
                    if (link.cw_valid) begin
                        data_next  = link.cw_data;
                        crc_next   = '0;
                        idx_next   = '0;
                        state_next = CHECK;
                    end
                end
                CHECK: begin
                    crc_next = crc_step;
                    idx_next = idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
                        out_msg_next   = data_reg[7:3];
                        syn_next       = syn_step;
                        out_ok_next    = (syn_step == 3'b000);
                        out_valid_next = 1'b1;
                        state_next     = DONE;
                    end
                end
                DONE: begin
                    if (link.out_ready) begin
                        out_valid_next = 1'b0;
                        state_next     = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Clear wins over a same-edge increment; both counters stick at all-ones.
    always_comb begin
        frame_cnt_next = frame_cnt_reg;
        err_cnt_next   = err_cnt_reg;
        if (en) begin
            if (clear_cnt) begin
                frame_cnt_next = '0;
                err_cnt_next   = '0;
            end else if (last_step) begin
                if (frame_cnt_reg != {CNT_W{1'b1}})
                    frame_cnt_next = frame_cnt_reg + CNT_ONE;
                if ((syn_step != 3'b000) && (err_cnt_reg != {CNT_W{1'b1}}))
                    err_cnt_next = err_cnt_reg + CNT_ONE;
            end
        end
    end

    assign link.cw_ready     = (state_reg == IDLE) && !reset;
    assign link.out_valid    = out_valid_reg;
    assign link.out_msg      = out_msg_reg;
    assign link.out_ok       = out_ok_reg;
    assign link.out_syndrome = syn_reg;
    assign frame_cnt         = frame_cnt_reg;
    assign err_cnt           = err_cnt_reg;
endmodule

// File: tb/tb_crc3_frame_checker.sv
// Directed bench for crc3_frame_checker: a CNT_W=8 unit plus a CNT_W=2
// unit fed identical stimulus so counter saturation can be observed.
module tb_crc3_frame_checker;
    logic clk = 1'b0;
    logic reset;
    logic en;
    logic clear_cnt;
    logic [7:0] frame_cnt, err_cnt;
    logic [1:0] sat_frame_cnt, sat_err_cnt;

    crc3_frame_checker_if bus ();
    crc3_frame_checker_if sat_bus ();

    assign sat_bus.cw_valid  = bus.cw_valid;
    assign sat_bus.cw_data   = bus.cw_data;
    assign sat_bus.out_ready = bus.out_ready;

    crc3_frame_checker #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .clear_cnt(clear_cnt),
        .link(bus.slave), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    crc3_frame_checker #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .clear_cnt(clear_cnt),
        .link(sat_bus.slave), .frame_cnt(sat_frame_cnt), .err_cnt(sat_err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_frm = 0, exp_err = 0, sat_frm = 0, sat_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the checker in IDLE; returns at the negedge after
    // the result handshake, again in IDLE. Expected values are supplied by the caller.
    task automatic run_frame(input logic [7:0] d, input logic exp_ok, input logic [2:0] exp_syn,
                             input int exp_lat, input int hold, input int stall_at,
                             input int stall_len, input logic clr);
        int lat;
        int drift;
        lat = 0;
        drift = 0;
        bus.cw_valid  = 1'b1;
        bus.cw_data   = d;
        bus.out_ready = (hold == 0);
        check("accept_ready", {31'd0, bus.cw_ready}, 32'd1);
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) bus.cw_data = ~d;
            if (stall_len > 0 && lat == stall_at) en = 1'b0;
            if (stall_len > 0 && lat == stall_at + stall_len) en = 1'b1;
            if (clr && lat == 8) clear_cnt = 1'b1;
            if (clr && lat == 9) clear_cnt = 1'b0;
        end while (!bus.out_valid && lat < 40);
        en = 1'b1;
        clear_cnt = 1'b0;
        check("latency", lat, exp_lat);
        check("out_msg", {27'd0, bus.out_msg}, {27'd0, d[7:3]});
        check("out_ok", {31'd0, bus.out_ok}, {31'd0, exp_ok});
        check("syndrome", {29'd0, bus.out_syndrome}, {29'd0, exp_syn});

        if (clr) begin
            exp_frm = 0; exp_err = 0; sat_frm = 0; sat_err = 0;
        end else begin
            if (exp_frm < 255) exp_frm++;
            if (!exp_ok && exp_err < 255) exp_err++;
            if (sat_frm < 3) sat_frm++;
            if (!exp_ok && sat_err < 3) sat_err++;
        end
        check("frame_cnt", {24'd0, frame_cnt}, exp_frm);
        check("err_cnt", {24'd0, err_cnt}, exp_err);
        check("sat_frame_cnt", {30'd0, sat_frame_cnt}, sat_frm);
        check("sat_err_cnt", {30'd0, sat_err_cnt}, sat_err);

        for (int k = 0; k < hold; k++) begin
            bus.cw_data = 8'($urandom);
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.cw_ready !== 1'b0 || bus.out_msg !== d[7:3] ||
                bus.out_ok !== exp_ok || bus.out_syndrome !== exp_syn)
                drift++;
        end
        if (hold > 0) check("done_hold_drift", drift, 0);

        bus.out_ready = 1'b1;
        @(negedge clk);
        check("pop_valid", {31'd0, bus.out_valid}, 32'd0);
        check("pop_ready", {31'd0, bus.cw_ready}, 32'd1);
        check("msg_after_pop", {27'd0, bus.out_msg}, {27'd0, d[7:3]});
        bus.cw_valid = 1'b0;
        $display("frame cw=%h msg=%b ok=%0d syn=%b lat=%0d frames=%0d errs=%0d",
                 d, bus.out_msg, bus.out_ok, bus.out_syndrome, lat, frame_cnt, err_cnt);
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b1;
        clear_cnt = 1'b0;
        bus.cw_valid = 1'b0;
        bus.cw_data = 8'h00;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cw_ready", {31'd0, bus.cw_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_msg", {27'd0, bus.out_msg}, 32'd0);
        check("rst_out_ok", {31'd0, bus.out_ok}, 32'd0);
        check("rst_syndrome", {29'd0, bus.out_syndrome}, 32'd0);
        check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, bus.cw_ready}, 32'd1);

        // Hand-run LFSR: 10110 -> 011, 00001 -> 011, 00000 -> 000.
        run_frame(8'hB3, 1'b1, 3'b000, 9, 0, 0, 0, 1'b0);
        run_frame(8'h0B, 1'b1, 3'b000, 9, 0, 0, 0, 1'b0);
        run_frame(8'h00, 1'b1, 3'b000, 9, 0, 0, 0, 1'b0);
        run_frame(8'hB2, 1'b0, 3'b001, 9, 0, 0, 0, 1'b0);
        run_frame(8'hB7, 1'b0, 3'b100, 9, 0, 0, 0, 1'b0);
        run_frame(8'hB3, 1'b1, 3'b000, 9, 20, 0, 0, 1'b0);
        run_frame(8'h0B, 1'b1, 3'b000, 9, 0, 0, 0, 1'b0);
        run_frame(8'hB3, 1'b1, 3'b000, 14, 0, 3, 5, 1'b0);

        // Reset in the middle of CHECK discards the frame and zeroes everything.
        bus.cw_valid = 1'b1;
        bus.cw_data = 8'hB3;
        @(posedge clk);
        @(negedge clk);
        bus.cw_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_ready", {31'd0, bus.cw_ready}, 32'd0);
        check("midrst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("midrst_out_msg", {27'd0, bus.out_msg}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_frm = 0; exp_err = 0; sat_frm = 0; sat_err = 0;
        @(negedge clk);
        check("midrst_ready_after", {31'd0, bus.cw_ready}, 32'd1);
        check("midrst_valid_after", {31'd0, bus.out_valid}, 32'd0);

        for (int n = 0; n < 5; n++)
            run_frame(8'hB2, 1'b0, 3'b001, 9, 0, 0, 0, 1'b0);
        run_frame(8'hB2, 1'b0, 3'b001, 9, 0, 0, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
